// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RISC-V memory-stage load/store unit; one req/gnt/rvalid transaction per accepted request.
// Build option: define LSU_MISALIGN_ERR_EN to fault misaligned accesses instead of force-aligning them.
module lsu_mem_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_load,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rdata,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t     state;
  logic       load_q;
  logic [2:0] funct3_q;
  logic [1:0] off_q;

  logic             legal;
  logic             take_err;
  logic [1:0]       eff_off;
  logic [3:0]       be_next;
  logic [WIDTH-1:0] wdata_next;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_data;

  // Request decode, evaluated against the live inputs while IDLE.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    legal      = 1'b0;
    eff_off    = addr[1:0];
    be_next    = 4'b1111;
    wdata_next = wdata;
    if (is_load ^ is_store) begin
      if (is_load) legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else         legal = funct3 inside {3'b000, 3'b001, 3'b010};
    end
    // Natural alignment: halfwords drop addr[0], words drop addr[1:0].
    case (funct3[1:0])
      2'b01:   eff_off = {addr[1], 1'b0};
      2'b10:   eff_off = 2'b00;
      default: eff_off = addr[1:0];
    endcase
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << eff_off;
          wdata_next = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_next    = 4'b0011 << {eff_off[1], 1'b0};
          wdata_next = {2{wdata[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = wdata;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_ERR_EN
  logic misaligned;
  assign misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                      (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign take_err   = !legal || misaligned;
`else
  assign take_err   = !legal;
`endif

  // Load extraction from the byte offset captured at accept time.
  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_err   <= 1'b0;
      load_q    <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            load_q   <= is_load;
            funct3_q <= funct3;
            off_q    <= eff_off;
            if (take_err) begin
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= '0;
              state     <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (load_q) begin
              state <= WAIT;
            end else begin
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              out_rdata <= '0;
              state     <= RESP;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= load_data;
            state     <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the RISC-V core's memory stage. It consumes the ALU result as the effective address, together with store data and `funct3`, and runs one data-memory transaction per accepted request over a req/gnt/rvalid bus. It generates byte enables and store-data lanes, and aligns and sign- or zero-extends load data. The result goes to writeback through a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 32: data and address width. Only 32 is supported.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid from the ALU/execute stage.
- `in_ready`  out  1  unit can accept a request.
- `is_load`  in  1  request is a load.
- `is_store`  in  1  request is a store.
- `funct3`  in  3  RISC-V access size and sign.
- `addr`  in  32  effective address (ALU `alu_out`).
- `wdata`  in  32  store data (rs2).
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address, with `[1:0]` = 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted by memory.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `out_valid`  out  1  result valid to writeback.
- `out_ready`  in  1  writeback accepts the result.
- `out_rdata`  out  32  extended load data; 0 for stores and errors.
- `out_err`  out  1  access fault.

## Operation
FSM states: IDLE, REQ, WAIT, RESP.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch `addr`, `wdata`, `funct3` and the op.
  - Illegal request: exactly one of `is_load`/`is_store` must be 1, and `funct3` must be legal (loads 000/001/010/100/101; stores 000/001/010). On illegal, or on misaligned when the feature is enabled, go to RESP with `out_err`=1 and issue no memory request.
  - Otherwise go to REQ.
- **REQ**
  - `mem_req`=1.
  - `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are registered and held stable until `mem_gnt`.
  - On `mem_gnt`: a store goes to RESP; a load goes to WAIT.
- **WAIT**
  - On `mem_rvalid`, register the extracted data and go to RESP.
  - `mem_rvalid` is ignored in all other states.
- **RESP**
  - `out_valid`=1, with data and error held stable.
  - On `out_ready`, go to IDLE. The next request is accepted no earlier than the following cycle.

Byte enables and store lanes:
- SB: `mem_be` = `4'b0001 << addr[1:0]`; `mem_wdata` = `{4{wdata[7:0]}}`.
- SH: `mem_be` = `4'b0011 << {addr[1],1'b0}`; `mem_wdata` = `{2{wdata[15:0]}}`.
- SW: `mem_be` = `4'b1111`; `mem_wdata` = `wdata`.
- Loads: `mem_be` = `4'b1111`, `mem_we`=0.

Load extraction:
- `sh` = `mem_rdata >> (8*addr[1:0])`.
- LB sign-extends `sh[7:0]`; LBU zero-extends it.
- LH sign-extends `sh[15:0]`; LHU zero-extends it.
- LW passes `mem_rdata` through.

Misaligned access: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, `out_valid`=0, `out_rdata`=0, `out_err`=0.
- Reset mid-transaction:
  - Abandon the transaction; `mem_req` and `out_valid` are 0 the cycle after reset.
  - A late `mem_rvalid` is ignored.
- Latency with zero-wait memory (accept at cycle T):
  - Store: REQ at T+1 with `mem_gnt` that cycle; `out_valid` at T+2.
  - Load: REQ at T+1; `mem_rvalid` at T+2; `out_valid` at T+3.
  - Error: `out_valid` at T+1.
- `mem_rvalid` earliest: the cycle after `mem_gnt`.
- Stall rules: back-pressure from `out_ready`=0 holds RESP indefinitely. `mem_gnt`=0 holds REQ with stable outputs.

## Configuration
- `LSU_MISALIGN_ERR_EN` defined: a misaligned access gives `out_err`=1, `out_rdata`=0, and no `mem_req`.
- Undefined: misaligned accesses execute with the address forced to natural alignment (`addr[0]` cleared for halfword; `addr[1:0]` cleared for word), and `out_err`=0.
- Illegal requests raise `out_err` in both builds.

## Test plan
- **LW, zero-wait:** LW `addr`=0x100 with `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_be`=1111; `out_rdata`=0xDEADBEEF at T+3.
- **LB / LBU:** LB `addr`=0x103 with `mem_rdata`=0x80xxxxxx → 0xFFFFFF80; LBU at the same address → 0x00000080.
- **SH:** SH `addr`=0x202, `wdata`=0x1234ABCD → `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; `out_valid` at T+2.
- **Stalls:** `mem_gnt` delayed 3 cycles and `out_ready` low for 2 cycles → request signals stable throughout; exactly one `out_valid` pulse train; `in_ready`=0 until accepted.
- **Misaligned LW:** LW `addr`=0x101. With the macro → `out_err`=1, no `mem_req`. Without it → `mem_addr`=0x100, `out_err`=0.
- **Illegal and reset:** `funct3`=011 load → `out_err` at T+1. Reset asserted in WAIT, then `mem_rvalid` → ignored, state IDLE, `out_valid`=0.
